block_stream_sequencer: RTL and testbench

BLOCK_STREAM_SEQUENCER -- requirements
Module: block_stream_sequencer

---
 rtl/block_stream_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_block_stream_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_stream_sequencer.sv
// block_stream_sequencer: streams SRAM blocks through a pipelined cipher
// and writes results back, bounding the number of blocks in flight.
module block_stream_sequencer #(
  parameter int ADDRSIZE     = 14,
  parameter int SRAMWIDTH    = 64,
  parameter int RD_LAT       = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDRSIZE-1:0]  in_base,
  input  logic [ADDRSIZE-1:0]  out_base,
  input  logic [ADDRSIZE-1:0]  num_blocks,
  output logic [ADDRSIZE-1:0]  in_addr,
  output logic                 in_rden,
  input  logic [SRAMWIDTH-1:0] in_q,
  output logic [SRAMWIDTH-1:0] cipher_data,
  output logic                 cipher_valid_in,
  input  logic [SRAMWIDTH-1:0] cipher_data_out,
  input  logic                 cipher_valid_out,
  output logic [ADDRSIZE-1:0]  out_addr,
  output logic [SRAMWIDTH-1:0] out_data,
  output logic                 out_wren,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           inflight,
  output logic [ADDRSIZE-1:0]  blocks_written
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_FLUSH
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_INFLIGHT);
  localparam logic [ADDRSIZE-1:0] LP_ONE = ADDRSIZE'(1);

  state_t r_state, w_next;

  logic [ADDRSIZE-1:0]  r_rd_ptr, r_wr_ptr;
  logic [ADDRSIZE-1:0]  r_issued, r_num, r_bw;
  logic [3:0]           r_inflight;
  logic [RD_LAT-1:0]    r_pipe;
  logic                 r_cv;
  logic [SRAMWIDTH-1:0] r_cd;
  logic                 r_wren;
  logic [SRAMWIDTH-1:0] r_wdata;
  logic                 r_done, r_err;

  logic w_active, w_start, w_abort;
  logic w_rden, w_accept, w_spurious, w_last;

  assign w_active   = (r_state == S_ISSUE) ||
                      (r_state == S_DRAIN);
  assign w_start    = start && (r_state == S_IDLE);
  assign w_abort    = abort && w_active;
  assign w_rden     = (r_state == S_ISSUE) &&
                      (r_inflight < LP_MAX) &&
                      (r_issued < r_num);
  assign w_accept   = cipher_valid_out &&
                      (r_inflight != 4'd0);
  assign w_spurious = cipher_valid_out &&
                      (r_inflight == 4'd0);
  assign w_last     = r_wren &&
                      (r_bw == r_num - LP_ONE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state; abort outranks start and completion
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start && num_blocks != '0)
          w_next = S_ISSUE;
      S_ISSUE:
        if (abort)                 w_next = S_FLUSH;
        else if (r_issued == r_num) w_next = S_DRAIN;
      S_DRAIN:
        if (abort)       w_next = S_FLUSH;
        else if (w_last) w_next = S_IDLE;
      S_FLUSH:
        if (r_inflight == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job bookkeeping: pointers, counters, done and err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_issued   <= '0;
      r_num      <= '0;
      r_bw       <= '0;
      r_inflight <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) &&
                (w_next == S_IDLE);
      if (w_rden) begin
        r_rd_ptr <= r_rd_ptr + LP_ONE;
        r_issued <= r_issued + LP_ONE;
      end
      if (r_wren) begin
        r_wr_ptr <= r_wr_ptr + LP_ONE;
        r_bw     <= r_bw + LP_ONE;
      end
      if (w_rden && !w_accept)
        r_inflight <= r_inflight + 4'd1;
      else if (!w_rden && w_accept)
        r_inflight <= r_inflight - 4'd1;
      if (w_start) begin
        r_err <= 1'b0;
        if (num_blocks == '0) begin
          r_done <= 1'b1;
        end else begin
          r_rd_ptr <= in_base;
          r_wr_ptr <= out_base;
          r_num    <= num_blocks;
          r_issued <= '0;
          r_bw     <= '0;
        end
      end
      if (w_spurious) r_err <= 1'b1;
    end
  end

  // SRAM read-latency pipeline feeding the cipher
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '0;
      r_cv   <= 1'b0;
      r_cd   <= '0;
    end else begin
      if (w_abort || r_state == S_FLUSH) begin
        r_pipe <= '0;
        r_cv   <= 1'b0;
      end else begin
        r_pipe[0] <= w_rden;
        for (int i = 1; i < RD_LAT; i++)
          r_pipe[i] <= r_pipe[i-1];
        r_cv <= r_pipe[RD_LAT-1];
      end
      if (r_pipe[RD_LAT-1]) r_cd <= in_q;
    end
  end

  // Output write port; flushed results are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wren  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wren <= w_accept && w_active;
      if (w_accept && w_active)
        r_wdata <= cipher_data_out;
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign in_addr         = r_rd_ptr;
  assign in_rden         = w_rden;
  assign cipher_data     = r_cd;
  assign cipher_valid_in = r_cv;
  assign out_addr        = r_wr_ptr;
  assign out_data        = r_wdata;
  assign out_wren        = r_wren;
  assign done            = r_done;
  assign err             = r_err;
  assign inflight        = r_inflight;
  assign blocks_written  = r_bw;

endmodule

// File: tb/tb_block_stream_sequencer.sv
// tb_block_stream_sequencer: directed jobs with SRAM and cipher models,
// scoreboard queues for reads, cipher handoffs and writes.
module tb_block_stream_sequencer;

  localparam int AW = 14;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] in_base = '0;
  logic [AW-1:0] out_base = '0;
  logic [AW-1:0] num_blocks = '0;
  logic [AW-1:0] in_addr;
  logic          in_rden;
  logic [DW-1:0] in_q = '0;
  logic [DW-1:0] cipher_data;
  logic          cipher_valid_in;
  logic [DW-1:0] cipher_data_out = '0;
  logic          cipher_valid_out = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_wren;
  logic          busy, done, err;
  logic [3:0]    inflight;
  logic [AW-1:0] blocks_written;

  block_stream_sequencer #(
    .ADDRSIZE(AW), .SRAMWIDTH(DW),
    .RD_LAT(2), .MAX_INFLIGHT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .start(start), .abort(abort),
    .in_base(in_base), .out_base(out_base),
    .num_blocks(num_blocks),
    .in_addr(in_addr), .in_rden(in_rden),
    .in_q(in_q),
    .cipher_data(cipher_data),
    .cipher_valid_in(cipher_valid_in),
    .cipher_data_out(cipher_data_out),
    .cipher_valid_out(cipher_valid_out),
    .out_addr(out_addr), .out_data(out_data),
    .out_wren(out_wren),
    .busy(busy), .done(done), .err(err),
    .inflight(inflight),
    .blocks_written(blocks_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem(
    input logic [AW-1:0] a);
    return {32'hC0DE_0000, 18'd0, a};
  endfunction

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } ev_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];
  ev_t           exp_cv[$];
  ev_t           cq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  // Input SRAM, two-cycle read latency
  logic [DW-1:0] s1 = '0, s2 = '0;
  always @(negedge clk) begin
    in_q = s2;
    s2   = s1;
    s1   = mem(in_addr);
  end

  // Cipher: echoes each block after lat cycles
  int            lat = 5;
  logic          inj = 1'b0;
  logic [DW-1:0] inj_data = 64'hDEAD_BEEF_0000_0001;
  ev_t           ce;
  always @(negedge clk) begin
    #1;
    if (!reset && cipher_valid_in) begin
      ce.due = cyc + lat;
      ce.d   = cipher_data;
      cq.push_back(ce);
    end
    cipher_valid_out = 1'b0;
    cipher_data_out  = '0;
    if (inj) begin
      cipher_valid_out = 1'b1;
      cipher_data_out  = inj_data;
    end else if (cq.size() > 0 && cq[0].due <= cyc) begin
      ce = cq.pop_front();
      cipher_valid_out = 1'b1;
      cipher_data_out  = ce.d;
    end
  end

  // Monitor: pops expectations as the DUT presents outputs
  int            done_cnt = 0, done_cyc = -1;
  int            rd_cnt = 0, first_rd = -1;
  int            max_infl = 0, start_cyc = 0;
  bit            busy_seen = 0;
  logic [AW-1:0] ma;
  ev_t           me;
  wr_t           mw;
  always @(negedge clk) begin
    if (!reset) begin
      if (in_rden) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_rd.size() == 0) unexp("rd_unexp");
        else begin
          ma = exp_rd.pop_front();
          chk("rd_addr", in_addr, ma);
          me.due = cyc + 3;
          me.d   = mem(ma);
          exp_cv.push_back(me);
        end
      end
      if (cipher_valid_in) begin
        if (exp_cv.size() == 0) unexp("cv_unexp");
        else begin
          me = exp_cv.pop_front();
          chk("cv_cycle", cyc, me.due);
          chk("cv_data", cipher_data, me.d);
        end
      end
      if (out_wren) begin
        if (exp_wr.size() == 0) unexp("wr_unexp");
        else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", out_addr, mw.a);
          chk("wr_data", out_data, mw.d);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (int'(inflight) > max_infl)
        max_infl = int'(inflight);
      if (busy) busy_seen = 1;
    end
  end

  task automatic start_job(input logic [AW-1:0] ib,
                           input logic [AW-1:0] ob,
                           input logic [AW-1:0] n,
                           input int nrd,
                           input int nwr);
    wr_t w;
    @(posedge clk);
    done_cnt  = 0;
    rd_cnt    = 0;
    first_rd  = -1;
    max_infl  = 0;
    busy_seen = 0;
    for (int i = 0; i < nrd; i++)
      exp_rd.push_back(ib + AW'(i));
    for (int i = 0; i < nwr; i++) begin
      w.a = ob + AW'(i);
      w.d = mem(ib + AW'(i));
      exp_wr.push_back(w);
    end
    @(negedge clk);
    in_base    = ib;
    out_base   = ob;
    num_blocks = n;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget,
                           input string nm);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      #2;
      if (!busy) break;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle",
               nm);
    end
  endtask

  task automatic q_empty(input string nm);
    chk({nm, "_rdq"}, exp_rd.size(), 0);
    chk({nm, "_wrq"}, exp_wr.size(), 0);
    chk({nm, "_cvq"}, exp_cv.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_infl", inflight, 0);
    chk("rst_bw", blocks_written, 0);
    chk("rst_rden", in_rden, 0);
    chk("rst_wren", out_wren, 0);
    chk("rst_cv", cipher_valid_in, 0);
    chk("rst_inaddr", in_addr, 0);
    chk("rst_outaddr", out_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // basic 3-block job
    lat = 5;
    start_job(14'h10, 14'h40, 3, 3, 3);
    wait_idle(200, "t1");
    repeat (3) @(negedge clk);
    #2;
    chk("t1_first_rd", first_rd, start_cyc + 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, start_cyc + 13);
    chk("t1_bw", blocks_written, 3);
    chk("t1_err", err, 0);
    q_empty("t1");

    // slow cipher, inflight cap, ignored restart
    lat = 20;
    start_job(14'h100, 14'h200, 10, 10, 10);
    repeat (4) @(negedge clk);
    in_base    = 14'h999;
    num_blocks = 5;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400, "t2");
    repeat (3) @(negedge clk);
    #2;
    chk("t2_max_infl", max_infl, 4);
    chk("t2_rd_cnt", rd_cnt, 10);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_bw", blocks_written, 10);
    q_empty("t2");

    // zero-length job
    start_job(14'h30, 14'h50, 0, 0, 0);
    repeat (4) @(negedge clk);
    #2;
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_cyc", done_cyc, start_cyc + 1);
    chk("t3_busy_seen", busy_seen, 0);
    chk("t3_rd_cnt", rd_cnt, 0);

    // address wrap on both ports
    lat = 3;
    start_job(14'h3FFE, 14'h3FFF, 4, 4, 4);
    wait_idle(200, "t4");
    repeat (3) @(negedge clk);
    #2;
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_bw", blocks_written, 4);
    chk("t4_in_addr", in_addr, 14'h0002);
    chk("t4_out_addr", out_addr, 14'h0003);
    q_empty("t4");

    // abort after two reads, two late results
    lat = 5;
    start_job(14'h80, 14'hA0, 6, 2, 0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    exp_cv.delete();
    @(negedge clk);
    abort = 1'b0;
    #2;
    chk("t5_infl_a", inflight, 2);
    chk("t5_busy_a", busy, 1);
    chk("t5_rd_cnt", rd_cnt, 2);
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #2;
    chk("t5_infl_b", inflight, 1);
    chk("t5_busy_b", busy, 1);
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    wait_idle(20, "t5");
    repeat (3) @(negedge clk);
    #2;
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_err", err, 0);
    chk("t5_infl", inflight, 0);
    chk("t5_bw", blocks_written, 0);
    q_empty("t5");

    // spurious result in idle, cleared by start
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #2;
    chk("t6_err_set", err, 1);
    chk("t6_infl", inflight, 0);
    lat = 4;
    start_job(14'h20, 14'h60, 1, 1, 1);
    #2;
    chk("t6_err_clr", err, 0);
    chk("t6_busy", busy, 1);
    wait_idle(100, "t6");
    repeat (3) @(negedge clk);
    #2;
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_bw", blocks_written, 1);
    q_empty("t6");

    // reset mid-job
    lat = 5;
    start_job(14'h10, 14'h40, 4, 4, 4);
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_rden", in_rden, 0);
    chk("t7_infl", inflight, 0);
    chk("t7_cv", cipher_valid_in, 0);
    @(posedge clk);
    exp_rd.delete();
    exp_wr.delete();
    exp_cv.delete();
    cq.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    chk("t7_done_cnt", done_cnt, 0);
    chk("t7_busy_end", busy, 0);
    chk("t7_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
